alu_seq_interface: RTL and testbench

ALU_SEQ_INTERFACE -- requirements
Module: alu_seq_interface

---
 rtl/alu_seq_interface.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_seq_interface.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_interface.sv
// Sequential ALU front panel: buttons step through A/B/OP, load switches into them, and show a registered result.
// Optional button debounce filter is compiled in with `define ALU_DEBOUNCE_EN.
module alu_seq_interface #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int DEB_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_switches,
  input  logic               i_btn_select,
  input  logic               i_btn_set,
  output logic [NB_DATA-1:0] o_leds,
  output logic [1:0]         o_sel,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_valid,
  output logic               o_error
);

  localparam logic [1:0] S_A  = 2'b00;
  localparam logic [1:0] S_B  = 2'b01;
  localparam logic [1:0] S_OP = 2'b10;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  localparam logic [NB_DATA:0] SHIFT_LIM = NB_DATA[NB_DATA:0];

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic       sel_pulse;
  logic       set_pulse;

  assign btn_raw   = {i_btn_set, i_btn_select};
  assign sel_pulse = btn_pulse[0];
  assign set_pulse = btn_pulse[1];

  // Per button: 2-flop synchronizer, optional level filter, rising-edge detector.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_q;
      logic sync2_q;
      logic level;
      logic prev_q;

      always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
        end
      end

`ifdef ALU_DEBOUNCE_EN
      localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             filt_q;
      logic             filt_d;

      // Counter tracks consecutive samples disagreeing with the filtered level.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
          if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            filt_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign level = filt_q;
`else
      assign level = sync2_q;
`endif

      always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= level;
        end
      end

      assign btn_pulse[gi] = level & ~prev_q;
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               a_ld_q, a_ld_d, b_ld_q, b_ld_d, op_ld_q, op_ld_d;
  logic               load_pend_q, load_pend_d;

  // Load uses the state before any same-cycle select advances it.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    a_ld_d      = a_ld_q;
    b_ld_d      = b_ld_q;
    op_ld_d     = op_ld_q;
    load_pend_d = 1'b0;
    case (state_q)
      S_A: begin
        if (set_pulse) begin
          a_d         = i_switches;
          a_ld_d      = 1'b1;
          load_pend_d = 1'b1;
        end
        if (sel_pulse) state_d = S_B;
      end
      S_B: begin
        if (set_pulse) begin
          b_d         = i_switches;
          b_ld_d      = 1'b1;
          load_pend_d = 1'b1;
        end
        if (sel_pulse) state_d = S_OP;
      end
      S_OP: begin
        if (set_pulse) begin
          op_d        = i_switches[NB_OP-1:0];
          op_ld_d     = 1'b1;
          load_pend_d = 1'b1;
        end
        if (sel_pulse) state_d = S_A;
      end
      default: state_d = S_A;
    endcase
  end

  logic [NB_DATA:0]   sum_ext, diff_ext;
  logic [NB_DATA-1:0] alu_res;
  logic               alu_c, alu_v, op_legal;
  logic               shift_big;

  always_comb begin
    sum_ext   = {1'b0, a_q} + {1'b0, b_q};
    diff_ext  = {1'b0, a_q} - {1'b0, b_q};
    shift_big = ({1'b0, b_q} >= SHIFT_LIM);
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    op_legal  = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[NB_DATA-1:0];
        alu_c   = sum_ext[NB_DATA];
        alu_v   = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) && (sum_ext[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[NB_DATA-1:0];
        alu_c   = diff_ext[NB_DATA];
        alu_v   = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) && (diff_ext[NB_DATA-1] != a_q[NB_DATA-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SRA: alu_res = shift_big ? {NB_DATA{a_q[NB_DATA-1]}} : NB_DATA'($signed(a_q) >>> b_q);
      OP_SRL: alu_res = shift_big ? '0 : (a_q >> b_q);
      default: op_legal = 1'b0;
    endcase
  end

  logic [NB_DATA-1:0] leds_q, leds_d;
  logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic               valid_q, valid_d, error_q, error_d;

  // Outputs refresh one cycle after a load; an illegal opcode freezes result and flags.
  always_comb begin
    leds_d  = leds_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    error_d = error_q;
    if (load_pend_q) begin
      if (op_legal) begin
        leds_d  = alu_res;
        zero_d  = (alu_res == '0);
        carry_d = alu_c;
        ovf_d   = alu_v;
        valid_d = a_ld_q & b_ld_q & op_ld_q;
        error_d = 1'b0;
      end else begin
        valid_d = 1'b0;
        error_d = op_ld_q;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      a_ld_q      <= 1'b0;
      b_ld_q      <= 1'b0;
      op_ld_q     <= 1'b0;
      load_pend_q <= 1'b0;
      leds_q      <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      a_ld_q      <= a_ld_d;
      b_ld_q      <= b_ld_d;
      op_ld_q     <= op_ld_d;
      load_pend_q <= load_pend_d;
      leds_q      <= leds_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign o_leds     = leds_q;
  assign o_sel      = state_q;
  assign o_zero     = zero_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_valid    = valid_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_alu_seq_interface.sv
// Directed bench for alu_seq_interface: button-driven loads, ALU ops, error handling, reset.
module tb_alu_seq_interface;

  logic       clk;
  logic       i_reset;
  logic [7:0] i_switches;
  logic       i_btn_select;
  logic       i_btn_set;
  logic [7:0] o_leds;
  logic [1:0] o_sel;
  logic       o_zero, o_carry, o_overflow, o_valid, o_error;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ALU_DEBOUNCE_EN
  localparam int PRESS_HI = 12;
  localparam int PRESS_LO = 10;
`else
  localparam int PRESS_HI = 3;
  localparam int PRESS_LO = 4;
`endif

  alu_seq_interface #(.NB_DATA(8), .NB_OP(6), .DEB_CYCLES(4)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_switches   (i_switches),
    .i_btn_select (i_btn_select),
    .i_btn_set    (i_btn_set),
    .o_leds       (o_leds),
    .o_sel        (o_sel),
    .o_zero       (o_zero),
    .o_carry      (o_carry),
    .o_overflow   (o_overflow),
    .o_valid      (o_valid),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic sel, input logic set, input int hi);
    @(negedge clk);
    i_btn_select = sel;
    i_btn_set    = set;
    repeat (hi) @(negedge clk);
    i_btn_select = 1'b0;
    i_btn_set    = 1'b0;
    repeat (PRESS_LO) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] sw);
    i_switches = sw;
    press(1'b0, 1'b1, PRESS_HI);
  endtask

  task automatic sel_step();
    press(1'b1, 1'b0, PRESS_HI);
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_leds, o_sel, o_zero, o_carry, o_overflow, o_valid, o_error} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: got leds=%h sel=%b z=%b c=%b v=%b valid=%b err=%b, want all 0",
               o_leds, o_sel, o_zero, o_carry, o_overflow, o_valid, o_error);
    end
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released: sel=%b leds=%h", o_sel, o_leds);
  endtask

  task automatic test_add();
    load(8'h0A);
    n_cmp++;
    if (o_valid !== 1'b0 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL add_partial: got valid=%b err=%b, want 0 0", o_valid, o_error);
    end
    sel_step();
    n_cmp++;
    if (o_sel !== 2'b01) begin n_fail++; $display("FAIL sel_to_b: got %b want 01", o_sel); end
    load(8'h05);
    sel_step();
    n_cmp++;
    if (o_sel !== 2'b10) begin n_fail++; $display("FAIL sel_to_op: got %b want 10", o_sel); end
    load(8'b0010_0000);
    $display("ADD 0A+05: leds=%h z=%b c=%b valid=%b", o_leds, o_zero, o_carry, o_valid);
    n_cmp++;
    if ({o_leds, o_zero, o_carry, o_overflow, o_valid, o_error} !== {8'h0F, 5'b00010}) begin
      n_fail++;
      $display("FAIL add_basic: got leds=%h z=%b c=%b v=%b valid=%b err=%b, want 0f 0 0 0 1 0",
               o_leds, o_zero, o_carry, o_overflow, o_valid, o_error);
    end
  endtask

  task automatic test_illegal_op();
    load(8'b0011_1111);
    $display("OP=111111: leds=%h valid=%b err=%b", o_leds, o_valid, o_error);
    n_cmp++;
    if ({o_leds, o_valid, o_error} !== {8'h0F, 2'b01}) begin
      n_fail++;
      $display("FAIL illegal_op: got leds=%h valid=%b err=%b, want 0f 0 1", o_leds, o_valid, o_error);
    end
  endtask

  task automatic test_add_overflow();
    sel_step();
    n_cmp++;
    if (o_sel !== 2'b00) begin n_fail++; $display("FAIL sel_wrap: got %b want 00", o_sel); end
    load(8'h80); sel_step(); load(8'h80); sel_step(); load(8'b0010_0000);
    $display("ADD 80+80: leds=%h z=%b c=%b v=%b", o_leds, o_zero, o_carry, o_overflow);
    n_cmp++;
    if ({o_leds, o_zero, o_carry, o_overflow, o_valid, o_error} !== {8'h00, 5'b11110}) begin
      n_fail++;
      $display("FAIL add_ovf: got leds=%h z=%b c=%b v=%b valid=%b err=%b, want 00 1 1 1 1 0",
               o_leds, o_zero, o_carry, o_overflow, o_valid, o_error);
    end
  endtask

  task automatic test_sub_shift();
    sel_step(); load(8'h05); sel_step(); load(8'h0A); sel_step(); load(8'b0010_0010);
    $display("SUB 05-0A: leds=%h c=%b v=%b", o_leds, o_carry, o_overflow);
    n_cmp++;
    if ({o_leds, o_zero, o_carry, o_overflow} !== {8'hFB, 3'b010}) begin
      n_fail++;
      $display("FAIL sub_borrow: got leds=%h z=%b c=%b v=%b, want fb 0 1 0", o_leds, o_zero, o_carry, o_overflow);
    end
    sel_step(); load(8'h80); sel_step(); load(8'h09); sel_step(); load(8'b0000_0011);
    $display("SRA 80>>>9: leds=%h", o_leds);
    n_cmp++;
    if ({o_leds, o_carry, o_overflow} !== {8'hFF, 2'b00}) begin
      n_fail++; $display("FAIL sra_big: got leds=%h c=%b v=%b, want ff 0 0", o_leds, o_carry, o_overflow);
    end
    load(8'b0000_0010);
    $display("SRL 80>>9: leds=%h z=%b", o_leds, o_zero);
    n_cmp++;
    if ({o_leds, o_zero} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL srl_big: got leds=%h z=%b, want 00 1", o_leds, o_zero);
    end
    sel_step(); sel_step(); load(8'h03); sel_step(); load(8'b0000_0010);
    $display("SRL 80>>3: leds=%h", o_leds);
    n_cmp++;
    if (o_leds !== 8'h10) begin n_fail++; $display("FAIL srl_3: got %h want 10", o_leds); end
    load(8'b0000_0011);
    $display("SRA 80>>>3: leds=%h", o_leds);
    n_cmp++;
    if (o_leds !== 8'hF0) begin n_fail++; $display("FAIL sra_3: got %h want f0", o_leds); end
  endtask

  task automatic test_logic_ops();
    logic [7:0] ops [4];
    logic [7:0] exp [4];
    ops = '{8'h24, 8'h25, 8'h26, 8'h27};
    exp = '{8'h0C, 8'h3F, 8'h33, 8'hC0};
    sel_step(); load(8'h3C); sel_step(); load(8'h0F); sel_step();
    for (int i = 0; i < 4; i++) begin
      load(ops[i]);
      $display("logic op %h on 3C,0F: leds=%h", ops[i], o_leds);
      n_cmp++;
      if ({o_leds, o_carry, o_valid} !== {exp[i], 2'b01}) begin
        n_fail++;
        $display("FAIL logic_op_%0d: got leds=%h c=%b valid=%b, want %h 0 1", i, o_leds, o_carry, o_valid, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    load(8'b0010_0000);
    sel_step(); load(8'h10); sel_step();
    i_switches = 8'h03;
    press(1'b1, 1'b1, PRESS_HI);
    $display("set+select in S_B: sel=%b leds=%h", o_sel, o_leds);
    n_cmp++;
    if ({o_sel, o_leds} !== {2'b10, 8'h13}) begin
      n_fail++; $display("FAIL set_sel_same: got sel=%b leds=%h, want 10 13", o_sel, o_leds);
    end
    sel_step(); sel_step();
    n_cmp++;
    if (o_sel !== 2'b01) begin n_fail++; $display("FAIL two_selects: got %b want 01", o_sel); end
    press(1'b1, 1'b0, 20);
    $display("held select: sel=%b", o_sel);
    n_cmp++;
    if (o_sel !== 2'b10) begin n_fail++; $display("FAIL held_button: got %b want 10", o_sel); end
  endtask

  task automatic test_reset_mid();
    i_switches   = 8'h77;
    i_btn_set    = 1'b1;
    i_btn_select = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    #2;
    n_cmp++;
    if ({o_leds, o_sel, o_zero, o_carry, o_overflow, o_valid, o_error} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_async: got leds=%h sel=%b valid=%b err=%b, want all 0", o_leds, o_sel, o_valid, o_error);
    end
    i_btn_set    = 1'b0;
    i_btn_select = 1'b0;
    repeat (4) @(negedge clk);
    i_reset = 1'b1;
    repeat (PRESS_LO) @(negedge clk);
    n_cmp++;
    if ({o_sel, o_leds, o_valid} !== 11'h0) begin
      n_fail++; $display("FAIL reset_pending_lost: got sel=%b leds=%h valid=%b, want 00 00 0", o_sel, o_leds, o_valid);
    end
    load(8'h12);
    $display("A only after reset: valid=%b err=%b", o_valid, o_error);
    n_cmp++;
    if ({o_valid, o_error} !== 2'b00) begin
      n_fail++; $display("FAIL a_only: got valid=%b err=%b, want 0 0", o_valid, o_error);
    end
  endtask

`ifdef ALU_DEBOUNCE_EN
  task automatic test_debounce();
    test_reset();
    press(1'b1, 1'b0, 3);
    $display("3-cycle glitch: sel=%b", o_sel);
    n_cmp++;
    if (o_sel !== 2'b00) begin n_fail++; $display("FAIL deb_glitch: got %b want 00", o_sel); end
    press(1'b1, 1'b0, 10);
    $display("10-cycle press: sel=%b", o_sel);
    n_cmp++;
    if (o_sel !== 2'b01) begin n_fail++; $display("FAIL deb_press: got %b want 01", o_sel); end
    i_btn_set = 1'b1;
    repeat (5) @(negedge clk);
    i_reset = 1'b0;
    #2;
    n_cmp++;
    if ({o_leds, o_sel, o_zero, o_carry, o_overflow, o_valid, o_error} !== 15'h0) begin
      n_fail++; $display("FAIL deb_reset: got leds=%h sel=%b, want 00 00", o_leds, o_sel);
    end
    i_btn_set = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    i_reset      = 1'b1;
    i_switches   = 8'h00;
    i_btn_select = 1'b0;
    i_btn_set    = 1'b0;
    #1;
    test_reset();
    test_add();
    test_illegal_op();
    test_add_overflow();
    test_sub_shift();
    test_logic_ops();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
